// File: rtl/alu_exec_stage.sv
// Execute stage: add/sub/or/and on two operands, result registered toward MEM
// behind a valid/ready handshake with a one-entry skid buffer for back-pressure.
module alu_exec_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_alu_signal,
    input  logic [DATA_W-1:0] in_op_a,
    input  logic [DATA_W-1:0] in_op_b,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_reg_write,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic              out_ovf,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_reg_write
);

    localparam int unsigned MSB = DATA_W - 1;

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_res_q, main_res_d;
    logic              main_zero_q, main_zero_d;
    logic              main_ovf_q, main_ovf_d;
    logic [RD_W-1:0]   main_rd_q, main_rd_d;
    logic              main_rw_q, main_rw_d;

    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_res_q, skid_res_d;
    logic              skid_ovf_q, skid_ovf_d;
    logic [RD_W-1:0]   skid_rd_q, skid_rd_d;
    logic              skid_rw_q, skid_rw_d;

    logic              in_ready_q, in_ready_d;

    logic [DATA_W-1:0] calc_res;
    logic              calc_ovf;
    logic              accept, xfer;
    logic              load_new_main, load_skid_main, load_skid;

    assign accept = in_valid & in_ready_q;
    assign xfer   = main_valid_q & out_ready;

    // ALU datapath on the incoming operands
    always_comb begin
        calc_res = '0;
        calc_ovf = 1'b0;
        case (in_alu_signal)
            2'b00: begin
                calc_res = in_op_a + in_op_b;
                calc_ovf = (in_op_a[MSB] == in_op_b[MSB]) & (calc_res[MSB] != in_op_a[MSB]);
            end
            2'b01: begin
                calc_res = in_op_a + ~in_op_b + DATA_W'(1);
                calc_ovf = (in_op_a[MSB] != in_op_b[MSB]) & (calc_res[MSB] != in_op_a[MSB]);
            end
            2'b10: calc_res = in_op_a | in_op_b;
            2'b11: calc_res = in_op_a & in_op_b;
        endcase
    end

    // Occupancy control: main register drains first, skid refills it
    always_comb begin
        main_valid_d   = main_valid_q;
        skid_valid_d   = skid_valid_q;
        load_new_main  = 1'b0;
        load_skid_main = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q) begin
            if (accept) begin
                load_new_main = 1'b1;
                main_valid_d  = 1'b1;
            end
        end else if (xfer) begin
            if (skid_valid_q) begin
                load_skid_main = 1'b1;
                skid_valid_d   = 1'b0;
            end else if (accept) begin
                load_new_main = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            load_skid    = 1'b1;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    // Payload muxing; payload holds its last value when not loaded
    always_comb begin
        main_res_d  = main_res_q;
        main_zero_d = main_zero_q;
        main_ovf_d  = main_ovf_q;
        main_rd_d   = main_rd_q;
        main_rw_d   = main_rw_q;
        skid_res_d  = skid_res_q;
        skid_ovf_d  = skid_ovf_q;
        skid_rd_d   = skid_rd_q;
        skid_rw_d   = skid_rw_q;
        if (load_new_main) begin
            main_res_d = calc_res;
            main_ovf_d = calc_ovf;
            main_rd_d  = in_rd;
            main_rw_d  = in_reg_write;
        end else if (load_skid_main) begin
            main_res_d = skid_res_q;
            main_ovf_d = skid_ovf_q;
            main_rd_d  = skid_rd_q;
            main_rw_d  = skid_rw_q;
        end
        if (load_new_main || load_skid_main) begin
            main_zero_d = (main_res_d == '0);
        end
        if (load_skid) begin
            skid_res_d = calc_res;
            skid_ovf_d = calc_ovf;
            skid_rd_d  = in_rd;
            skid_rw_d  = in_reg_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_res_q   <= '0;
            main_zero_q  <= 1'b0;
            main_ovf_q   <= 1'b0;
            main_rd_q    <= '0;
            main_rw_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_res_q   <= '0;
            skid_ovf_q   <= 1'b0;
            skid_rd_q    <= '0;
            skid_rw_q    <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            main_res_q   <= main_res_d;
            main_zero_q  <= main_zero_d;
            main_ovf_q   <= main_ovf_d;
            main_rd_q    <= main_rd_d;
            main_rw_q    <= main_rw_d;
            skid_valid_q <= skid_valid_d;
            skid_res_q   <= skid_res_d;
            skid_ovf_q   <= skid_ovf_d;
            skid_rd_q    <= skid_rd_d;
            skid_rw_q    <= skid_rw_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = main_valid_q;
    assign out_result    = main_res_q;
    assign out_zero      = main_zero_q;
    assign out_ovf       = main_ovf_q;
    assign out_rd        = main_rd_q;
    assign out_reg_write = main_rw_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed + random bench for alu_exec_stage; expected results queue on accept
// and are compared while held at the output, popped on transfer.
module tb_alu_exec_stage;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_alu_signal;
    logic [31:0] in_op_a;
    logic [31:0] in_op_b;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_ovf;
    logic [4:0]  out_rd;
    logic        out_reg_write;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    alu_exec_stage #(.DATA_W(32), .RD_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_signal(in_alu_signal), .in_op_a(in_op_a), .in_op_b(in_op_b),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_ovf(out_ovf),
        .out_rd(out_rd), .out_reg_write(out_reg_write)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference ALU using wide signed arithmetic for overflow detection
    function automatic exp_t model(input logic [1:0] sig, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] rd, input logic rw);
        exp_t   e;
        longint sa, sb2, r;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        e.ovf = 1'b0;
        e.res = '0;
        case (sig)
            2'b00: begin
                r = sa + sb2;
                e.res = r[31:0];
                e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            2'b01: begin
                r = sa - sb2;
                e.res = r[31:0];
                e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            2'b10: e.res = a | b;
            default: e.res = a & b;
        endcase
        e.zero = (e.res == 32'd0);
        e.rd   = rd;
        e.rw   = rw;
        return e;
    endfunction

    // One cycle: drive at negedge, check held outputs, update scoreboard, advance
    task automatic step(input logic v, input logic [1:0] sig, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic rw, input logic ordy, input logic fl,
                        input logic use_exp, input exp_t ex);
        logic acc, xf;
        in_valid = v; in_alu_signal = sig; in_op_a = a; in_op_b = b;
        in_rd = rd; in_reg_write = rw; out_ready = ordy; flush = fl;
        acc = v && (sb.size() < 2);
        xf  = (sb.size() != 0) && ordy;
        chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(sb.size() < 2));
        if (sb.size() != 0) begin
            chk("out_result", out_result, sb[0].res);
            chk("out_zero", 32'(out_zero), 32'(sb[0].zero));
            chk("out_ovf", 32'(out_ovf), 32'(sb[0].ovf));
            chk("out_rd", 32'(out_rd), 32'(sb[0].rd));
            chk("out_reg_write", 32'(out_reg_write), 32'(sb[0].rw));
        end
        if (fl) begin
            sb.delete();
        end else begin
            if (xf) void'(sb.pop_front());
            if (acc) sb.push_back(use_exp ? ex : model(sig, a, b, rd, rw));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic op(input logic [1:0] sig, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic ordy);
        step(1'b1, sig, a, b, rd, 1'b1, ordy, 1'b0, 1'b0, '0);
    endtask

    task automatic op_exp(input logic [1:0] sig, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] res, input logic z, input logic o);
        exp_t e;
        e.res = res; e.zero = z; e.ovf = o; e.rd = rd; e.rw = 1'b1;
        step(1'b1, sig, a, b, rd, 1'b1, 1'b1, 1'b0, 1'b1, e);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 1'b0, ordy, 1'b0, 1'b0, '0);
    endtask

    task automatic reset_outputs_zero();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd0);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_out_reg_write", 32'(out_reg_write), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_alu_signal = 2'b00; in_op_a = '0; in_op_b = '0;
        in_rd = '0; in_reg_write = 1'b0; flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset_outputs_zero();
        rst_n = 1'b1;
        idle(1'b1);
        idle(1'b1);

        // Basic ops and overflow corners with literal expectations
        op_exp(2'b01, 32'd5, 32'd5, 5'd4, 32'h0000_0000, 1'b1, 1'b0);
        op_exp(2'b10, 32'hF0, 32'h0F, 5'd5, 32'h0000_00FF, 1'b0, 1'b0);
        op_exp(2'b11, 32'hF0, 32'h3C, 5'd6, 32'h0000_0030, 1'b0, 1'b0);
        op_exp(2'b00, 32'h7FFF_FFFF, 32'd1, 5'd7, 32'h8000_0000, 1'b0, 1'b1);
        op_exp(2'b01, 32'h8000_0000, 32'd1, 5'd8, 32'h7FFF_FFFF, 1'b0, 1'b1);
        op_exp(2'b00, 32'hFFFF_FFFF, 32'd1, 5'd9, 32'h0000_0000, 1'b1, 1'b0);
        idle(1'b1);

        // Back-pressure: two accepted, third stalls, then drain in order
        op(2'b00, 32'd1, 32'd2, 5'd1, 1'b0);
        op(2'b01, 32'd10, 32'd3, 5'd2, 1'b0);
        op(2'b10, 32'd1, 32'd2, 5'd3, 1'b0);
        op(2'b10, 32'd1, 32'd2, 5'd3, 1'b0);
        op(2'b10, 32'd1, 32'd2, 5'd3, 1'b1);
        op(2'b10, 32'd1, 32'd2, 5'd3, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Flush with both entries full and a new op offered
        op(2'b00, 32'd100, 32'd1, 5'd10, 1'b0);
        op(2'b00, 32'd200, 32'd2, 5'd11, 1'b0);
        step(1'b1, 2'b00, 32'd300, 32'd3, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0, '0);
        repeat (3) idle(1'b1);

        // Reset mid-stream with skid full
        op(2'b00, 32'd7, 32'd8, 5'd13, 1'b0);
        op(2'b01, 32'd7, 32'd8, 5'd14, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        #1;
        reset_outputs_zero();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) idle(1'b1);

        // Streaming at full throughput
        for (int i = 0; i < 100; i++) begin
            op(2'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom_range(0, 31)), 1'b1);
        end
        idle(1'b1);

        // Random valid/ready/flush mix
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom,
                 ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom,
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0, 1'b0, '0);
        end
        repeat (3) idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
